// File: rtl/vram_arbiter_pkg.sv
// Shared types and default sizing for the VRAM port arbiter.
// Imported by the arbiter top and its write queue.
package vram_arbiter_pkg;

    localparam int ADDR_W_DEF     = 12;
    localparam int DATA_W_DEF     = 8;
    localparam int WQ_DEPTH_DEF   = 4;
    localparam int STARVE_MAX_DEF = 16;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_WQ,
        GNT_CPU_RD,
        GNT_PPU
    } grant_t;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_WAIT,
        RD_DATA
    } rd_state_t;

endpackage

// File: rtl/vram_write_fifo.sv
// Posted-write queue of {address, data} for CPU stores to VRAM.
// Push is dropped when full; pop is dropped when empty.
module vram_write_fifo
    import vram_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = WQ_DEPTH_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    push,
    input  logic [ADDR_W-1:0]       push_address,
    input  logic [DATA_W-1:0]       push_data,
    input  logic                    pop,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  level,
    output logic [ADDR_W-1:0]       head_address,
    output logic [DATA_W-1:0]       head_data
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [LVL_W-1:0]  count;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == LVL_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign level        = count;
    assign head_address = addr_mem[rd_ptr];
    assign head_data    = data_mem[rd_ptr];

    // Storage needs no reset: only entries below count are ever read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            addr_mem[wr_ptr] <= push_address;
            data_mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter between the 6502 bus and the PPU fetch engine.
// PPU owns the port in active display, CPU owns it in vblank.
module vram_arbiter
    import vram_arbiter_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int WQ_DEPTH   = WQ_DEPTH_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_vblank,
    input  logic                        cpu_valid,
    input  logic                        cpu_write,
    input  logic [ADDR_W-1:0]           cpu_address,
    input  logic [DATA_W-1:0]           cpu_wdata,
    output logic [DATA_W-1:0]           cpu_rdata,
    output logic                        cpu_rdy,
    input  logic                        ppu_req,
    input  logic [ADDR_W-1:0]           ppu_address,
    output logic                        ppu_gnt,
    output logic                        ppu_rdata_valid,
    output logic [DATA_W-1:0]           ppu_rdata,
    output logic                        vram_en,
    output logic                        vram_we,
    output logic [ADDR_W-1:0]           vram_address,
    output logic [DATA_W-1:0]           vram_wdata,
    input  logic [DATA_W-1:0]           vram_rdata,
    output logic [$clog2(WQ_DEPTH):0]   wq_level
);

    localparam int STARVE_W = $clog2(STARVE_MAX + 1);
    localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

    grant_t            grant;
    rd_state_t         rd_state;
    logic              rd_data_q;
    logic [STARVE_W-1:0] starve_cnt;

    logic              wq_push;
    logic              wq_pop;
    logic              wq_full;
    logic              wq_empty;
    logic [ADDR_W-1:0] wq_head_address;
    logic [DATA_W-1:0] wq_head_data;

    logic              wq_elig;
    logic              rd_elig;
    logic              starved;

    vram_write_fifo #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (WQ_DEPTH)
    ) u_wq (
        .clk          (clk),
        .rst_n        (rst_n),
        .push         (wq_push),
        .push_address (cpu_address),
        .push_data    (cpu_wdata),
        .pop          (wq_pop),
        .full         (wq_full),
        .empty        (wq_empty),
        .level        (wq_level),
        .head_address (wq_head_address),
        .head_data    (wq_head_data)
    );

    // Writes see start-of-cycle full; reads complete only in the data cycle.
    assign cpu_rdy = rst_n && cpu_valid &&
                     (cpu_write ? !wq_full : rd_data_q);
    assign wq_push = cpu_valid && cpu_write && cpu_rdy;
    assign wq_pop  = (grant == GNT_WQ);

    assign wq_elig = !wq_empty;
    assign rd_elig = (rd_state == RD_WAIT) && wq_empty;
    assign starved = (starve_cnt == STARVE_LIM);

    always_comb begin
        grant = GNT_NONE;
        if (!rst_n) begin
            grant = GNT_NONE;
        end else if (in_vblank) begin
            if (wq_elig) begin
                grant = GNT_WQ;
            end else if (rd_elig) begin
                grant = GNT_CPU_RD;
            end else if (ppu_req) begin
                grant = GNT_PPU;
            end
        end else begin
            if (wq_elig && starved) begin
                grant = GNT_WQ;
            end else if (ppu_req) begin
                grant = GNT_PPU;
            end else if (wq_elig) begin
                grant = GNT_WQ;
            end else if (rd_elig) begin
                grant = GNT_CPU_RD;
            end
        end
    end

    always_comb begin
        vram_en      = (grant != GNT_NONE);
        vram_we      = (grant == GNT_WQ);
        vram_address = '0;
        vram_wdata   = '0;
        case (grant)
            GNT_WQ: begin
                vram_address = wq_head_address;
                vram_wdata   = wq_head_data;
            end
            GNT_CPU_RD: vram_address = cpu_address;
            GNT_PPU:    vram_address = ppu_address;
            default:    vram_address = '0;
        endcase
    end

    assign ppu_gnt   = (grant == GNT_PPU);
    assign ppu_rdata = ppu_rdata_valid ? vram_rdata : '0;
    assign cpu_rdata = rd_data_q ? vram_rdata : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_state  <= RD_IDLE;
            rd_data_q <= 1'b0;
        end else begin
            rd_data_q <= 1'b0;
            case (rd_state)
                RD_IDLE: begin
                    if (cpu_valid && !cpu_write) begin
                        rd_state <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (grant == GNT_CPU_RD) begin
                        rd_state  <= RD_DATA;
                        rd_data_q <= 1'b1;
                    end
                end
                RD_DATA: rd_state <= RD_IDLE;
                default: rd_state <= RD_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ppu_rdata_valid <= 1'b0;
        end else begin
            ppu_rdata_valid <= ppu_gnt;
        end
    end

    // Bounds how long display fetches can hold off posted writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (wq_empty || grant == GNT_WQ) begin
            starve_cnt <= '0;
        end else if (!in_vblank && !starved) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a behavioural synchronous VRAM.
module tb_vram_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_vblank;
    logic        cpu_valid;
    logic        cpu_write;
    logic [11:0] cpu_address;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic        cpu_rdy;
    logic        ppu_req;
    logic [11:0] ppu_address;
    logic        ppu_gnt;
    logic        ppu_rdata_valid;
    logic [7:0]  ppu_rdata;
    logic        vram_en;
    logic        vram_we;
    logic [11:0] vram_address;
    logic [7:0]  vram_wdata;
    logic [7:0]  vram_rdata;
    logic [2:0]  wq_level;

    int nvec = 0;
    int nerr = 0;

    logic [7:0] mem [4096];
    logic       loaded = 1'b0;

    always #5 clk = ~clk;

    // Memory preload: mem[a] = a[7:0] ^ 8'h5A.
    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < 4096; i++) mem[i] <= 8'(i) ^ 8'h5A;
            loaded <= 1'b1;
        end else if (vram_en) begin
            if (vram_we) mem[vram_address] <= vram_wdata;
            else         vram_rdata <= mem[vram_address];
        end
    end

    vram_arbiter dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_vblank       (in_vblank),
        .cpu_valid       (cpu_valid),
        .cpu_write       (cpu_write),
        .cpu_address     (cpu_address),
        .cpu_wdata       (cpu_wdata),
        .cpu_rdata       (cpu_rdata),
        .cpu_rdy         (cpu_rdy),
        .ppu_req         (ppu_req),
        .ppu_address     (ppu_address),
        .ppu_gnt         (ppu_gnt),
        .ppu_rdata_valid (ppu_rdata_valid),
        .ppu_rdata       (ppu_rdata),
        .vram_en         (vram_en),
        .vram_we         (vram_we),
        .vram_address    (vram_address),
        .vram_wdata      (vram_wdata),
        .vram_rdata      (vram_rdata),
        .wq_level        (wq_level)
    );

    task automatic idle_inputs();
        cpu_valid   = 1'b0;
        cpu_write   = 1'b0;
        cpu_address = '0;
        cpu_wdata   = '0;
        ppu_req     = 1'b0;
        ppu_address = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_vblank = 1'b0;
        idle_inputs();
        cpu_valid = 1'b1;
        cpu_write = 1'b1;
        ppu_req = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        nvec++; if (cpu_rdy !== 1'b0) begin nerr++; $display("FAIL rst_cpu_rdy: got %b want 0", cpu_rdy); end
        nvec++; if (ppu_gnt !== 1'b0) begin nerr++; $display("FAIL rst_ppu_gnt: got %b want 0", ppu_gnt); end
        nvec++; if (ppu_rdata_valid !== 1'b0) begin nerr++; $display("FAIL rst_ppu_rv: got %b want 0", ppu_rdata_valid); end
        nvec++; if ({vram_en, vram_we} !== 2'b00) begin nerr++; $display("FAIL rst_en_we: got %b want 00", {vram_en, vram_we}); end
        nvec++; if (vram_address !== 12'h000) begin nerr++; $display("FAIL rst_vaddr: got %h want 000", vram_address); end
        nvec++; if (vram_wdata !== 8'h00) begin nerr++; $display("FAIL rst_vwdata: got %h want 00", vram_wdata); end
        nvec++; if (cpu_rdata !== 8'h00) begin nerr++; $display("FAIL rst_cpu_rdata: got %h want 00", cpu_rdata); end
        nvec++; if (ppu_rdata !== 8'h00) begin nerr++; $display("FAIL rst_ppu_rdata: got %h want 00", ppu_rdata); end
        nvec++; if (wq_level !== 3'd0) begin nerr++; $display("FAIL rst_wq_level: got %0d want 0", wq_level); end
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_vblank_wr_rd();
        @(negedge clk);
        in_vblank = 1'b1;
        cpu_valid = 1'b1; cpu_write = 1'b1;
        cpu_address = 12'h123; cpu_wdata = 8'hA5;
        #1;
        nvec++; if (cpu_rdy !== 1'b1) begin nerr++; $display("FAIL wr_zero_wait: got %b want 1", cpu_rdy); end
        nvec++; if (vram_en !== 1'b0) begin nerr++; $display("FAIL wr_no_early_en: got %b want 0", vram_en); end
        @(negedge clk);
        cpu_write = 1'b0; cpu_wdata = 8'h00;
        #1;
        nvec++; if (vram_we !== 1'b1) begin nerr++; $display("FAIL wr_ram_we: got %b want 1", vram_we); end
        nvec++; if (vram_address !== 12'h123) begin nerr++; $display("FAIL wr_ram_addr: got %h want 123", vram_address); end
        nvec++; if (vram_wdata !== 8'hA5) begin nerr++; $display("FAIL wr_ram_data: got %h want a5", vram_wdata); end
        nvec++; if (cpu_rdy !== 1'b0) begin nerr++; $display("FAIL rd_idle_rdy: got %b want 0", cpu_rdy); end
        @(negedge clk);
        #1;
        nvec++; if ({vram_en, vram_we} !== 2'b10) begin nerr++; $display("FAIL rd_issue: got %b want 10", {vram_en, vram_we}); end
        nvec++; if (vram_address !== 12'h123) begin nerr++; $display("FAIL rd_issue_addr: got %h want 123", vram_address); end
        nvec++; if (cpu_rdy !== 1'b0) begin nerr++; $display("FAIL rd_issue_rdy: got %b want 0", cpu_rdy); end
        @(negedge clk);
        #1;
        nvec++; if (cpu_rdy !== 1'b1) begin nerr++; $display("FAIL rd_data_rdy: got %b want 1", cpu_rdy); end
        nvec++; if (cpu_rdata !== 8'hA5) begin nerr++; $display("FAIL rd_data: got %h want a5", cpu_rdata); end
        @(negedge clk);
        cpu_valid = 1'b0;
        #1;
        nvec++; if (vram_en !== 1'b0) begin nerr++; $display("FAIL rd_done_idle: got %b want 0", vram_en); end
    endtask

    task automatic test_queue_fill();
        int found;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_vblank = 1'b0;
            ppu_req = 1'b1; ppu_address = 12'h200;
            cpu_valid = 1'b1; cpu_write = 1'b1;
            cpu_address = 12'(12'h300 + i);
            cpu_wdata = 8'(8'h10 + i);
            #1;
            nvec++; if (cpu_rdy !== 1'b1) begin nerr++; $display("FAIL fill_accept%0d: got %b want 1", i, cpu_rdy); end
            nvec++; if (ppu_gnt !== 1'b1) begin nerr++; $display("FAIL fill_ppu%0d: got %b want 1", i, ppu_gnt); end
        end
        @(negedge clk);
        cpu_address = 12'h304; cpu_wdata = 8'h14;
        #1;
        nvec++; if (cpu_rdy !== 1'b0) begin nerr++; $display("FAIL fill_full_stall: got %b want 0", cpu_rdy); end
        nvec++; if (wq_level !== 3'd4) begin nerr++; $display("FAIL fill_level4: got %0d want 4", wq_level); end
        found = -1;
        for (int c = 5; c < 40; c++) begin
            @(negedge clk);
            #1;
            if (vram_we === 1'b1) begin
                found = c;
                break;
            end
        end
        nvec++; if (found != 17) begin nerr++; $display("FAIL starve_cycle: got %0d want 17", found); end
        nvec++; if (cpu_rdy !== 1'b0) begin nerr++; $display("FAIL no_passthru: got %b want 0", cpu_rdy); end
        nvec++; if (ppu_gnt !== 1'b0) begin nerr++; $display("FAIL starve_ppu_held: got %b want 0", ppu_gnt); end
        nvec++; if (vram_address !== 12'h300) begin nerr++; $display("FAIL starve_addr: got %h want 300", vram_address); end
        nvec++; if (vram_wdata !== 8'h10) begin nerr++; $display("FAIL starve_data: got %h want 10", vram_wdata); end
        nvec++; if (ppu_rdata !== 8'h5A) begin nerr++; $display("FAIL fill_ppu_data: got %h want 5a", ppu_rdata); end
        @(negedge clk);
        #1;
        nvec++; if (cpu_rdy !== 1'b1) begin nerr++; $display("FAIL fill_5th_accept: got %b want 1", cpu_rdy); end
        nvec++; if (wq_level !== 3'd3) begin nerr++; $display("FAIL fill_level3: got %0d want 3", wq_level); end
        @(negedge clk);
        cpu_valid = 1'b0;
        ppu_req = 1'b0;
        in_vblank = 1'b1;
        #1;
        nvec++; if (wq_level !== 3'd4) begin nerr++; $display("FAIL fill_relevel4: got %0d want 4", wq_level); end
        repeat (4) @(negedge clk);
        #1;
        nvec++; if (wq_level !== 3'd0) begin nerr++; $display("FAIL fill_drain: got %0d want 0", wq_level); end
        nvec++; if (mem[12'h304] !== 8'h14) begin nerr++; $display("FAIL fill_ram_304: got %h want 14", mem[12'h304]); end
    endtask

    task automatic test_read_order();
        int issue;
        int done;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_vblank = 1'b0;
            ppu_req = 1'b1; ppu_address = 12'h040;
            cpu_valid = 1'b1; cpu_write = 1'b1;
            cpu_address = 12'(12'h010 + i);
            cpu_wdata = 8'(8'h31 + i);
            #1;
            nvec++; if (cpu_rdy !== 1'b1) begin nerr++; $display("FAIL ord_accept%0d: got %b want 1", i, cpu_rdy); end
        end
        @(negedge clk);
        cpu_write = 1'b0; cpu_address = 12'h012; cpu_wdata = 8'h00;
        #1;
        nvec++; if (wq_level !== 3'd3) begin nerr++; $display("FAIL ord_level3: got %0d want 3", wq_level); end
        issue = -1;
        done = -1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (c == 0) ppu_req = 1'b0;
            #1;
            if (vram_en === 1'b1 && vram_we === 1'b0 && issue < 0) begin
                issue = c;
                nvec++; if (wq_level !== 3'd0) begin nerr++; $display("FAIL ord_issue_level: got %0d want 0", wq_level); end
                nvec++; if (vram_address !== 12'h012) begin nerr++; $display("FAIL ord_issue_addr: got %h want 012", vram_address); end
            end
            if (cpu_rdy === 1'b1) begin
                done = c;
                nvec++; if (cpu_rdata !== 8'h33) begin nerr++; $display("FAIL ord_rdata: got %h want 33", cpu_rdata); end
                break;
            end
        end
        nvec++; if (issue != 3) begin nerr++; $display("FAIL ord_issue_cycle: got %0d want 3", issue); end
        nvec++; if (done != 4) begin nerr++; $display("FAIL ord_done_cycle: got %0d want 4", done); end
        @(negedge clk);
        cpu_valid = 1'b0;
    endtask

    task automatic test_ppu_priority();
        @(negedge clk);
        in_vblank = 1'b0;
        ppu_req = 1'b0;
        cpu_valid = 1'b1; cpu_write = 1'b1;
        cpu_address = 12'h055; cpu_wdata = 8'h77;
        #1;
        nvec++; if (cpu_rdy !== 1'b1) begin nerr++; $display("FAIL pp_accept: got %b want 1", cpu_rdy); end
        @(negedge clk);
        cpu_valid = 1'b0;
        ppu_req = 1'b1; ppu_address = 12'h0AB;
        #1;
        nvec++; if (ppu_gnt !== 1'b1) begin nerr++; $display("FAIL pp_gnt: got %b want 1", ppu_gnt); end
        nvec++; if (vram_we !== 1'b0) begin nerr++; $display("FAIL pp_we_held: got %b want 0", vram_we); end
        nvec++; if (vram_address !== 12'h0AB) begin nerr++; $display("FAIL pp_addr: got %h want 0ab", vram_address); end
        nvec++; if (wq_level !== 3'd1) begin nerr++; $display("FAIL pp_level1: got %0d want 1", wq_level); end
        @(negedge clk);
        ppu_req = 1'b0;
        #1;
        nvec++; if (ppu_rdata_valid !== 1'b1) begin nerr++; $display("FAIL pp_rvalid: got %b want 1", ppu_rdata_valid); end
        nvec++; if (ppu_rdata !== 8'hF1) begin nerr++; $display("FAIL pp_rdata: got %h want f1", ppu_rdata); end
        nvec++; if (vram_we !== 1'b1) begin nerr++; $display("FAIL pp_wr_follow: got %b want 1", vram_we); end
        nvec++; if (vram_address !== 12'h055) begin nerr++; $display("FAIL pp_wr_addr: got %h want 055", vram_address); end
        nvec++; if (vram_wdata !== 8'h77) begin nerr++; $display("FAIL pp_wr_data: got %h want 77", vram_wdata); end
        @(negedge clk);
        #1;
        nvec++; if (wq_level !== 3'd0) begin nerr++; $display("FAIL pp_drained: got %0d want 0", wq_level); end
        nvec++; if (ppu_rdata_valid !== 1'b0) begin nerr++; $display("FAIL pp_rvalid_drop: got %b want 0", ppu_rdata_valid); end
    endtask

    task automatic test_priority_flip();
        @(negedge clk);
        in_vblank = 1'b0;
        ppu_req = 1'b1; ppu_address = 12'h0C0;
        cpu_valid = 1'b1; cpu_write = 1'b1;
        cpu_address = 12'h0C1; cpu_wdata = 8'h99;
        #1;
        nvec++; if (cpu_rdy !== 1'b1) begin nerr++; $display("FAIL flip_accept: got %b want 1", cpu_rdy); end
        @(negedge clk);
        cpu_write = 1'b0; cpu_wdata = 8'h00;
        #1;
        nvec++; if (ppu_gnt !== 1'b1) begin nerr++; $display("FAIL flip_ppu_first: got %b want 1", ppu_gnt); end
        nvec++; if (wq_level !== 3'd1) begin nerr++; $display("FAIL flip_level1: got %0d want 1", wq_level); end
        @(negedge clk);
        in_vblank = 1'b1;
        #1;
        nvec++; if ({vram_en, vram_we, ppu_gnt} !== 3'b110) begin nerr++; $display("FAIL flip_wq: got %b want 110", {vram_en, vram_we, ppu_gnt}); end
        nvec++; if (vram_address !== 12'h0C1) begin nerr++; $display("FAIL flip_wq_addr: got %h want 0c1", vram_address); end
        @(negedge clk);
        #1;
        nvec++; if ({vram_en, vram_we, ppu_gnt} !== 3'b100) begin nerr++; $display("FAIL flip_cpu_rd: got %b want 100", {vram_en, vram_we, ppu_gnt}); end
        nvec++; if (vram_address !== 12'h0C1) begin nerr++; $display("FAIL flip_rd_addr: got %h want 0c1", vram_address); end
        @(negedge clk);
        #1;
        nvec++; if (cpu_rdy !== 1'b1) begin nerr++; $display("FAIL flip_rd_rdy: got %b want 1", cpu_rdy); end
        nvec++; if (cpu_rdata !== 8'h99) begin nerr++; $display("FAIL flip_rdata: got %h want 99", cpu_rdata); end
        nvec++; if (ppu_gnt !== 1'b1) begin nerr++; $display("FAIL flip_ppu_last: got %b want 1", ppu_gnt); end
        nvec++; if (vram_address !== 12'h0C0) begin nerr++; $display("FAIL flip_ppu_addr: got %h want 0c0", vram_address); end
        @(negedge clk);
        cpu_valid = 1'b0;
        ppu_req = 1'b0;
        #1;
        nvec++; if (ppu_rdata !== 8'h9A) begin nerr++; $display("FAIL flip_ppu_rdata: got %h want 9a", ppu_rdata); end
    endtask

    task automatic test_reset_mid_read();
        int done;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            in_vblank = 1'b0;
            ppu_req = 1'b1; ppu_address = 12'h0D0;
            cpu_valid = 1'b1; cpu_write = 1'b1;
            cpu_address = 12'(12'h0E0 + i);
            cpu_wdata = 8'(8'h11 * (i + 1));
            #1;
            nvec++; if (cpu_rdy !== 1'b1) begin nerr++; $display("FAIL mr_accept%0d: got %b want 1", i, cpu_rdy); end
        end
        @(negedge clk);
        cpu_write = 1'b0; cpu_address = 12'h0E0; cpu_wdata = 8'h00;
        @(negedge clk);
        #1;
        nvec++; if (wq_level !== 3'd2) begin nerr++; $display("FAIL mr_level2: got %0d want 2", wq_level); end
        nvec++; if (cpu_rdy !== 1'b0) begin nerr++; $display("FAIL mr_wait_rdy: got %b want 0", cpu_rdy); end
        #1;
        rst_n = 1'b0;
        #1;
        nvec++; if (cpu_rdy !== 1'b0) begin nerr++; $display("FAIL mr_cpu_rdy: got %b want 0", cpu_rdy); end
        nvec++; if (ppu_gnt !== 1'b0) begin nerr++; $display("FAIL mr_ppu_gnt: got %b want 0", ppu_gnt); end
        nvec++; if (ppu_rdata_valid !== 1'b0) begin nerr++; $display("FAIL mr_ppu_rv: got %b want 0", ppu_rdata_valid); end
        nvec++; if ({vram_en, vram_we} !== 2'b00) begin nerr++; $display("FAIL mr_en_we: got %b want 00", {vram_en, vram_we}); end
        nvec++; if (vram_address !== 12'h000) begin nerr++; $display("FAIL mr_vaddr: got %h want 000", vram_address); end
        nvec++; if (ppu_rdata !== 8'h00) begin nerr++; $display("FAIL mr_ppu_rdata: got %h want 00", ppu_rdata); end
        nvec++; if (wq_level !== 3'd0) begin nerr++; $display("FAIL mr_wq_level: got %0d want 0", wq_level); end
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        in_vblank = 1'b1;
        cpu_valid = 1'b1; cpu_write = 1'b0; cpu_address = 12'h0E0;
        done = -1;
        for (int c = 0; c < 10; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            if (cpu_rdy === 1'b1) begin
                done = c;
                nvec++; if (cpu_rdata !== 8'hBA) begin nerr++; $display("FAIL mr_post_rdata: got %h want ba", cpu_rdata); end
                break;
            end
        end
        nvec++; if (done != 2) begin nerr++; $display("FAIL mr_post_latency: got %0d want 2", done); end
        @(negedge clk);
        cpu_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_vblank_wr_rd();
        test_queue_fill();
        test_read_order();
        test_ppu_priority();
        test_priority_flip();
        test_reset_mid_read();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Arbitrates the single VRAM port, covering the pmf, pmb, ntbl, obm and txbl regions at 0x4000–0x4fff, between the 6502 bus and the PPU fetch engine. CPU writes are posted into a small write queue so stores never stall while the queue has room. CPU reads wait for the queue to drain, which preserves program order. Priority flips on `in_vblank`: the PPU owns the port during active display, and the CPU owns it during vblank.

## Interface
- `ADDR_W`, 12: VRAM word address width (offset from 0x4000).
- `DATA_W`, 8: data width.
- `WQ_DEPTH`, 4: write-queue entries; power of two, ≥2.
- `STARVE_MAX`, 16: cycles a non-empty queue may be denied during active display before it is forced one grant.
- `clk` in 1: system clock; all state on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_vblank` in 1: high during vertical blank.
- `cpu_valid` in 1: CPU access to VRAM pending (address decode already qualified); held until `cpu_rdy`.
- `cpu_write` in 1: 1 = write, 0 = read; stable while `cpu_valid`.
- `cpu_address` in ADDR_W: VRAM offset.
- `cpu_wdata` in DATA_W: write data.
- `cpu_rdata` out DATA_W: read data, valid when `cpu_rdy && cpu_valid && !cpu_write`.
- `cpu_rdy` out 1: transfer completes on a cycle with `cpu_valid && cpu_rdy`.
- `ppu_req` in 1: PPU read request, level.
- `ppu_address` in ADDR_W: PPU read address.
- `ppu_gnt` out 1: PPU read issued this cycle.
- `ppu_rdata_valid` out 1: `ppu_rdata` valid; one cycle after `ppu_gnt`.
- `ppu_rdata` out DATA_W: PPU read data.
- `vram_en` out 1, `vram_we` out 1, `vram_address` out ADDR_W, `vram_wdata` out DATA_W: synchronous RAM port.
- `vram_rdata` in DATA_W: RAM read data, one cycle after `vram_en && !vram_we`.
- `wq_level` out $clog2(WQ_DEPTH)+1: current queue occupancy.

## Operation
- **Grant per cycle.** At most one grant: NONE, WQ (queue head write), CPU_RD, or PPU. The grant is combinational from current state and inputs and drives `vram_*` in the same cycle.
- **Priority, `in_vblank`=1:** WQ > CPU_RD > PPU.
- **Priority, `in_vblank`=0:** PPU > WQ > CPU_RD. When the starve counter equals STARVE_MAX, WQ outranks PPU for that cycle.
- **Starve counter.**
  - Increments on cycles where the queue is non-empty, `in_vblank`=0, and WQ is not granted.
  - Clears on any WQ grant or when the queue is empty.
  - Saturates at STARVE_MAX.
- **CPU writes.**
  - `cpu_rdy` = !full; entry {address, data} enqueued on the handshake.
  - When enqueue and dequeue happen in the same cycle while full: the dequeue frees a slot, but `cpu_rdy` still reflects start-of-cycle full. There is no same-cycle pass-through.
- **CPU read FSM:**
  - RD_IDLE. `cpu_valid && !cpu_write` goes to RD_WAIT.
  - RD_WAIT. CPU_RD is eligible only when the queue is empty. A granted read goes to RD_DATA.
  - RD_DATA. `cpu_rdy`=1, `cpu_rdata`=`vram_rdata`, then back to RD_IDLE.
  - `cpu_rdy`=0 during RD_WAIT, during RD_DATA's issuing cycle, and for a read in RD_IDLE.
- **PPU path.** `ppu_gnt` issues a read at `ppu_address`. `ppu_rdata_valid` is registered and follows one cycle later with `ppu_rdata`=`vram_rdata`.
- **`vram_wdata`.** Driven from the queue head on WQ grants, 0 otherwise.
- **`in_vblank` toggles.** Priority switches on the next grant decision. An issued read always completes its data cycle.
- **Reset mid-operation.**
  - Queue flushed (posted writes lost) and FSM forced to RD_IDLE.
  - `ppu_rdata_valid` and the starve counter cleared.
  - A CPU read in flight is abandoned.

## Timing
- **Reset values:**
  - `cpu_rdy`=0, `ppu_gnt`=0, `ppu_rdata_valid`=0.
  - `vram_en`=0, `vram_we`=0, `vram_address`=0, `vram_wdata`=0.
  - `cpu_rdata`=0, `ppu_rdata`=0, `wq_level`=0.
  - `cpu_rdy` is gated low while `rst_n`=0.
- **Write acceptance:** 0 wait cycles when not full. The RAM write occurs ≥1 cycle after acceptance.
- **CPU read:** minimum 2 cycles (issue, data) with an empty queue in vblank. Otherwise it waits for queue drain plus grant.
- **PPU read:** grant same cycle as `ppu_req` when it wins; data 1 cycle later. In active display the PPU can be delayed by at most one cycle per STARVE_MAX+1.

## Structure
- **`vram_arbiter_pkg`:**
  - `grant_t` enum {GNT_NONE, GNT_WQ, GNT_CPU_RD, GNT_PPU}.
  - `rd_state_t` enum {RD_IDLE, RD_WAIT, RD_DATA}.
  - Default width constants.
- **Sub-module `vram_write_fifo`:**
  - Synchronous FIFO of {address, data}.
  - Ports: push/pop, full/empty, level, head.
  - Same clock and reset.

## Test plan
- **Vblank write-then-read.**
  - Stimulus: `in_vblank`=1, CPU write 0x123←0xA5, then read 0x123.
  - Required: write accepted in 0 waits; RAM write next cycle; read returns 0xA5, `cpu_rdy` 2 cycles after read presented.
- **Queue fill in active display.**
  - Stimulus: `in_vblank`=0, `ppu_req` held high, 5 back-to-back writes.
  - Required: first 4 accepted (`wq_level`=4); 5th stalls until the starve-forced WQ grant at cycle STARVE_MAX, then is accepted.
- **Read ordering.**
  - Stimulus: 3 queued writes to 0x010–0x012, then read 0x012.
  - Required: read issues only after `wq_level`=0 and returns the last written value.
- **PPU priority.**
  - Stimulus: `in_vblank`=0, simultaneous `ppu_req` and queued write.
  - Required: `ppu_gnt`=1 that cycle, `ppu_rdata_valid`=1 next cycle with correct data; the write follows when `ppu_req` drops.
- **Priority flip.**
  - Stimulus: `in_vblank` 0→1 with `ppu_req`, a CPU read and a queued write all pending.
  - Required: the next grant goes to WQ, then CPU_RD, then PPU.
- **Reset mid-read.**
  - Stimulus: assert `rst_n`=0 during RD_WAIT with 2 queued writes.
  - Required: all outputs at reset values, `wq_level`=0; after release, a new read completes normally.
